// File: rtl/boundary_row_buffer_if.sv
// Capture stream from the last PE and replay handshake towards the first PE.
interface boundary_row_buffer_if #(
  parameter int CALC_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10
);
  logic                            cap_valid;
  logic signed [CALC_WIDTH-1:0]    cap_H;
  logic signed [CALC_WIDTH-1:0]    cap_F;
  logic signed [CALC_WIDTH-1:0]    cap_F_hat;
  logic signed [CALC_WIDTH-1:0]    cap_max;
  logic        [ADDRESS_WIDTH-1:0] cap_x;
  logic        [ADDRESS_WIDTH-1:0] cap_y;

  logic                            rep_req;
  logic                            rep_valid;
  logic signed [CALC_WIDTH-1:0]    rep_H;
  logic signed [CALC_WIDTH-1:0]    rep_F;
  logic signed [CALC_WIDTH-1:0]    rep_F_hat;

  // PE chain / feeder side
  modport master (
    output cap_valid, cap_H, cap_F, cap_F_hat, cap_max, cap_x, cap_y, rep_req,
    input  rep_valid, rep_H, rep_F, rep_F_hat
  );

  // Row buffer side
  modport slave (
    input  cap_valid, cap_H, cap_F, cap_F_hat, cap_max, cap_x, cap_y, rep_req,
    output rep_valid, rep_H, rep_F, rep_F_hat
  );
endinterface

// File: rtl/boundary_row_buffer.sv
// Boundary row buffer: captures the last PE's row per pass into ping-pong
// banks, replays the previous pass's row, and tracks the global best score.
module boundary_row_buffer #(
  parameter int CALC_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DEPTH         = 1024,
  parameter logic signed [CALC_WIDTH-1:0] NEG_INF = CALC_WIDTH'(-(2**(CALC_WIDTH-2)))
) (
  input  logic                            clk,
  input  logic                            reset_i,
  input  logic                            pass_start_i,
  input  logic                            first_pass_i,
  input  logic        [ADDRESS_WIDTH-1:0] t_len_i,
  boundary_row_buffer_if.slave            bus,
  output logic signed [CALC_WIDTH-1:0]    best_max_o,
  output logic        [ADDRESS_WIDTH-1:0] best_x_o,
  output logic        [ADDRESS_WIDTH-1:0] best_y_o,
  output logic                            pass_done_o,
  output logic                            overflow_o
);

  localparam int WORD_W = 3 * CALC_WIDTH;

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;

  state_t                         state_q;
  logic                           wr_bank_q;
  logic [ADDRESS_WIDTH-1:0]       wr_ptr_q;
  logic [ADDRESS_WIDTH-1:0]       rd_ptr_q;
  logic [1:0]                     complete_q;
  logic                           first_q;
  logic [ADDRESS_WIDTH-1:0]       tlen_q;
  logic signed [CALC_WIDTH-1:0]   best_max_q;
  logic [ADDRESS_WIDTH-1:0]       best_x_q;
  logic [ADDRESS_WIDTH-1:0]       best_y_q;
  logic                           pass_done_q;
  logic                           overflow_q;
  logic                           rep_valid_q;
  logic                           rep_init_q;
  logic                           rep_bank_q;

  // Pass-start-adjusted view of the state: a pass_start_i takes effect before
  // the same-cycle capture, replay request and best comparison are evaluated.
  state_t                         state_s;
  logic                           wr_bank_s;
  logic                           rd_bank_s;
  logic [ADDRESS_WIDTH-1:0]       wr_ptr_s;
  logic [ADDRESS_WIDTH-1:0]       rd_ptr_s;
  logic [1:0]                     complete_s;
  logic                           first_s;
  logic [ADDRESS_WIDTH-1:0]       tlen_s;
  logic signed [CALC_WIDTH-1:0]   best_max_s;
  logic [ADDRESS_WIDTH-1:0]       best_x_s;
  logic [ADDRESS_WIDTH-1:0]       best_y_s;
  logic                           wr_en;
  logic                           wr_last;
  logic                           rep_init_s;
  logic                           best_upd;
  logic [WORD_W-1:0]              wdata;
  logic [WORD_W-1:0]              rep_word;

  assign wdata = {bus.cap_H, bus.cap_F, bus.cap_F_hat};

  // Apply pass_start_i first, then derive write/replay/best decisions.
  always_comb begin
    state_s    = state_q;
    wr_bank_s  = wr_bank_q;
    wr_ptr_s   = wr_ptr_q;
    rd_ptr_s   = rd_ptr_q;
    complete_s = complete_q;
    first_s    = first_q;
    tlen_s     = tlen_q;
    best_max_s = best_max_q;
    best_x_s   = best_x_q;
    best_y_s   = best_y_q;
    if (pass_start_i) begin
      state_s    = (t_len_i == '0) ? FULL : ACTIVE;
      wr_bank_s  = ~wr_bank_q;
      wr_ptr_s   = '0;
      rd_ptr_s   = '0;
      complete_s[wr_bank_s] = 1'b0;
      first_s    = first_pass_i;
      tlen_s     = t_len_i;
      if (first_pass_i) begin
        best_max_s = '0;
        best_x_s   = '0;
        best_y_s   = '0;
      end
    end
    rd_bank_s  = ~wr_bank_s;
    wr_en      = bus.cap_valid && (state_s == ACTIVE);
    wr_last    = wr_en && (wr_ptr_s == (tlen_s - ADDRESS_WIDTH'(1)));
    rep_init_s = first_s || !complete_s[rd_bank_s] || (rd_ptr_s >= tlen_s);
    best_upd   = bus.cap_valid && (bus.cap_max > best_max_s);
  end

  // Control FSM, pointers, completion flags, best tracking and replay tags.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      complete_q  <= '0;
      first_q     <= 1'b1;
      tlen_q      <= '0;
      best_max_q  <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      pass_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      rep_valid_q <= 1'b0;
      rep_init_q  <= 1'b0;
      rep_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_s;
      wr_bank_q   <= wr_bank_s;
      wr_ptr_q    <= wr_ptr_s;
      complete_q  <= complete_s;
      first_q     <= first_s;
      tlen_q      <= tlen_s;
      pass_done_q <= 1'b0;
      case (state_s)
        ACTIVE: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_s + ADDRESS_WIDTH'(1);
            if (wr_last) begin
              state_q     <= FULL;
              pass_done_q <= 1'b1;
              complete_q[wr_bank_s] <= 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.cap_valid) overflow_q <= 1'b1;
        end
        default: ;
      endcase

      if (bus.rep_req && (rd_ptr_s < tlen_s)) rd_ptr_q <= rd_ptr_s + ADDRESS_WIDTH'(1);
      else                                    rd_ptr_q <= rd_ptr_s;

      if (best_upd) begin
        best_max_q <= bus.cap_max;
        best_x_q   <= bus.cap_x;
        best_y_q   <= bus.cap_y;
      end else begin
        best_max_q <= best_max_s;
        best_x_q   <= best_x_s;
        best_y_q   <= best_y_s;
      end

      rep_valid_q <= bus.rep_req;
      if (bus.rep_req) begin
        rep_init_q <= rep_init_s;
        rep_bank_q <= rd_bank_s;
      end
    end
  end

  // Ping-pong banks; read and write always target different banks.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Capture write port
    always_ff @(posedge clk) begin
      if (wr_en && (wr_bank_s == 1'(b))) mem[wr_ptr_s] <= wdata;
    end

    // Registered replay read port
    always_ff @(posedge clk) begin
      if (bus.rep_req && (rd_bank_s == 1'(b))) rdata_q <= mem[rd_ptr_s];
    end
  end

  assign rep_word = rep_bank_q ? g_bank[1].rdata_q : g_bank[0].rdata_q;

  // Replay outputs: initial values when the row is unavailable, 0 when idle.
  always_comb begin
    bus.rep_valid = rep_valid_q;
    bus.rep_H     = '0;
    bus.rep_F     = '0;
    bus.rep_F_hat = '0;
    if (rep_valid_q) begin
      if (rep_init_q) begin
        bus.rep_F     = NEG_INF;
        bus.rep_F_hat = NEG_INF;
      end else begin
        bus.rep_H     = rep_word[3*CALC_WIDTH-1 -: CALC_WIDTH];
        bus.rep_F     = rep_word[2*CALC_WIDTH-1 -: CALC_WIDTH];
        bus.rep_F_hat = rep_word[CALC_WIDTH-1 -: CALC_WIDTH];
      end
    end
  end

  assign best_max_o  = best_max_q;
  assign best_x_o    = best_x_q;
  assign best_y_o    = best_y_q;
  assign pass_done_o = pass_done_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_boundary_row_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// pass-level reference model (rows kept as queues per pass).
module tb_boundary_row_buffer;
  localparam int CW = 16;
  localparam int AW = 10;
  localparam int NEG_INF = -16384;

  logic          clk;
  logic          reset_i;
  logic          pass_start_i;
  logic          first_pass_i;
  logic [AW-1:0] t_len_i;
  logic signed [CW-1:0] best_max_o;
  logic [AW-1:0] best_x_o;
  logic [AW-1:0] best_y_o;
  logic          pass_done_o;
  logic          overflow_o;

  boundary_row_buffer_if #(.CALC_WIDTH(CW), .ADDRESS_WIDTH(AW)) bus ();

  boundary_row_buffer #(.CALC_WIDTH(CW), .ADDRESS_WIDTH(AW), .DEPTH(1024)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .pass_start_i (pass_start_i),
    .first_pass_i (first_pass_i),
    .t_len_i      (t_len_i),
    .bus          (bus),
    .best_max_o   (best_max_o),
    .best_x_o     (best_x_o),
    .best_y_o     (best_y_o),
    .pass_done_o  (pass_done_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int h; int f; int fh; } ent_t;
  ent_t cur_q[$];
  ent_t prev_q[$];
  bit   m_run, m_done, prev_ok, m_first, m_ovf;
  int   m_tlen, m_rd;
  int   m_best, m_bx, m_by;
  bit   exp_valid, exp_dc, exp_done;
  int   exp_h, exp_f, exp_fh;

  task automatic model_reset();
    cur_q.delete(); prev_q.delete();
    m_run = 0; m_done = 0; prev_ok = 0; m_first = 1; m_ovf = 0;
    m_tlen = 0; m_rd = 0; m_best = 0; m_bx = 0; m_by = 0;
    exp_valid = 0; exp_dc = 0; exp_done = 0;
    exp_h = 0; exp_f = 0; exp_fh = 0;
  endtask

  task automatic model_step(input bit ps, input bit fp, input int tl, input bit cv,
                            input int h, input int f, input int fh, input int mx,
                            input int x, input int y, input bit rq);
    exp_done = 0;
    if (ps) begin
      prev_q  = cur_q;
      prev_ok = m_done;
      cur_q.delete();
      m_done = 0; m_tlen = tl; m_first = fp; m_rd = 0; m_run = 1;
      if (fp) begin m_best = 0; m_bx = 0; m_by = 0; end
    end
    exp_valid = rq;
    exp_dc = 0;
    if (rq) begin
      if (m_first || !prev_ok || m_rd >= m_tlen) begin
        exp_h = 0; exp_f = NEG_INF; exp_fh = NEG_INF;
      end else if (m_rd < prev_q.size()) begin
        exp_h = prev_q[m_rd].h; exp_f = prev_q[m_rd].f; exp_fh = prev_q[m_rd].fh;
      end else begin
        exp_dc = 1;
      end
      if (m_rd < m_tlen) m_rd++;
    end
    if (cv) begin
      if (m_run) begin
        if (!m_done && cur_q.size() < m_tlen) begin
          cur_q.push_back('{h: h, f: f, fh: fh});
          if (cur_q.size() == m_tlen) begin m_done = 1; exp_done = 1; end
        end else begin
          m_ovf = 1;
        end
      end
      if (mx > m_best) begin m_best = mx; m_bx = x; m_by = y; end
    end
  endtask

  task automatic check_outputs();
    check("rep_valid", int'(bus.rep_valid), int'(exp_valid));
    if (exp_valid && !exp_dc) begin
      check("rep_H", int'(bus.rep_H), exp_h);
      check("rep_F", int'(bus.rep_F), exp_f);
      check("rep_F_hat", int'(bus.rep_F_hat), exp_fh);
    end
    check("pass_done", int'(pass_done_o), int'(exp_done));
    check("overflow", int'(overflow_o), int'(m_ovf));
    check("best_max", int'(best_max_o), m_best);
    check("best_x", int'(best_x_o), m_bx);
    check("best_y", int'(best_y_o), m_by);
  endtask

  // Drive one cycle at the negedge, step the model, check after the posedge.
  task automatic drive(input bit ps, input bit fp, input int tl, input bit cv,
                       input int h, input int f, input int fh, input int mx,
                       input int x, input int y, input bit rq);
    pass_start_i  = ps;
    first_pass_i  = fp;
    t_len_i       = AW'(tl);
    bus.cap_valid = cv;
    bus.cap_H     = CW'(h);
    bus.cap_F     = CW'(f);
    bus.cap_F_hat = CW'(fh);
    bus.cap_max   = CW'(mx);
    bus.cap_x     = AW'(x);
    bus.cap_y     = AW'(y);
    bus.rep_req   = rq;
    model_step(ps, fp, tl, cv, h, f, fh, mx, x, y, rq);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_idle_inputs();
    pass_start_i = 0; first_pass_i = 0; t_len_i = '0;
    bus.cap_valid = 0; bus.cap_H = '0; bus.cap_F = '0; bus.cap_F_hat = '0;
    bus.cap_max = '0; bus.cap_x = '0; bus.cap_y = '0; bus.rep_req = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rep_valid"}, int'(bus.rep_valid), 0);
    check({tag, "_rep_H"}, int'(bus.rep_H), 0);
    check({tag, "_rep_F"}, int'(bus.rep_F), 0);
    check({tag, "_rep_F_hat"}, int'(bus.rep_F_hat), 0);
    check({tag, "_best_max"}, int'(best_max_o), 0);
    check({tag, "_best_x"}, int'(best_x_o), 0);
    check({tag, "_best_y"}, int'(best_y_o), 0);
    check({tag, "_pass_done"}, int'(pass_done_o), 0);
    check({tag, "_overflow"}, int'(overflow_o), 0);
  endtask

  function automatic int rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  initial begin
    set_idle_inputs();
    reset_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_i = 1'b1;

    // First pass: replay of initial values
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("init_H", int'(bus.rep_H), 0);
      check("init_F", int'(bus.rep_F), NEG_INF);
      check("init_F_hat", int'(bus.rep_F_hat), NEG_INF);
    end

    // Capture a 3-entry row
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, -3, -3, 1, 1, 1, 0);
    check("done_early", int'(pass_done_o), 0);
    drive(0, 0, 0, 1, 7, -3, -3, 2, 2, 2, 0);
    drive(0, 0, 0, 1, 2, -3, -3, 3, 3, 3, 0);
    check("pass_done_pulse", int'(pass_done_o), 1);
    idle();
    check("pass_done_clear", int'(pass_done_o), 0);

    // Overflow capture in FULL still updates best
    drive(0, 0, 0, 1, 99, 99, 99, 9, 4, 4, 0);
    check("overflow_set", int'(overflow_o), 1);
    check("best_after_ovf", int'(best_max_o), 9);
    idle();
    check("overflow_sticky", int'(overflow_o), 1);

    // Second pass replays the captured row
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("replay0_H", int'(bus.rep_H), 5);
    check("replay0_F", int'(bus.rep_F), -3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("replay1_H", int'(bus.rep_H), 7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("replay2_H", int'(bus.rep_H), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("replay_past_H", int'(bus.rep_H), 0);
    check("replay_past_F", int'(bus.rep_F), NEG_INF);
    idle();
    check("rep_valid_idle", int'(bus.rep_valid), 0);

    // Best tracking with ties
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    check("best_cleared", int'(best_max_o), 0);
    drive(0, 0, 0, 1, 1, 1, 1, 4, 2, 1, 0);
    check("best_a_max", int'(best_max_o), 4);
    check("best_a_x", int'(best_x_o), 2);
    check("best_a_y", int'(best_y_o), 1);
    drive(0, 0, 0, 1, 1, 1, 1, 4, 3, 5, 0);
    check("best_tie_x", int'(best_x_o), 2);
    check("best_tie_y", int'(best_y_o), 1);
    drive(0, 0, 0, 1, 1, 1, 1, 6, 0, 7, 0);
    check("best_c_max", int'(best_max_o), 6);
    check("best_c_x", int'(best_x_o), 0);
    check("best_c_y", int'(best_y_o), 7);

    // pass_start coincident with capture, then request coincident with pass_start
    drive(1, 0, 2, 1, 11, 21, 31, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 12, 22, 32, 0, 0, 0, 0);
    check("coinc_done", int'(pass_done_o), 1);
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    check("coinc_replay_H", int'(bus.rep_H), 11);
    check("coinc_replay_F_hat", int'(bus.rep_F_hat), 31);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("coinc_replay1_H", int'(bus.rep_H), 12);

    // Asynchronous reset mid-ACTIVE
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8, 8, 8, 3, 5, 6, 1);
    set_idle_inputs();
    #2 reset_i = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    drive(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("post_reset_H", int'(bus.rep_H), 0);
    check("post_reset_F", int'(bus.rep_F), NEG_INF);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit ps, fp, cv, rq;
      int tl;
      ps = m_done ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0);
      fp = ($urandom_range(3) == 0);
      tl = ($urandom_range(9) == 0) ? int'($urandom_range(1)) : int'($urandom_range(12));
      cv = ($urandom_range(9) < 6);
      rq = ($urandom_range(1) == 1);
      if (c == 1500) begin
        set_idle_inputs();
        #2 reset_i = 1'b0;
        #1 check_all_zero("rand_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
      end
      drive(ps, fp, tl, cv, rnd16(), rnd16(), rnd16(), int'($urandom_range(60)) - 20,
            int'($urandom_range(1023)), int'($urandom_range(1023)), rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
